// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display driver.
// Segment patterns are active-high in {g,f,e,d,c,b,a} order.
package seven_seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'h00;

   // Entry n holds the glyph for hex digit n (index 15 listed first).
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-high seven-segment glyph.
module seven_seg_decoder
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed hex display driver: refresh scanning, double-buffered load,
// decimal points, blanking, leading-zero suppression and pin polarity control.
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    blank,
   input  logic                    lz_en,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int IW = idx_width(NUM_DIGITS);
   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   // XOR masks that turn active-high internal values into pin levels.
   localparam logic [6:0]            SEG_POL = {7{SEG_ACTIVE_LOW}};
   localparam logic                  DP_POL  = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{AN_ACTIVE_LOW}};

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic                    slot_end;
   logic                    wrap;
   logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
   logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
   logic [NUM_DIGITS-1:0]   supp;
   logic [NUM_DIGITS-1:0]   an_sel;
   logic [3:0]              nibble;
   logic                    dp_sel;
   logic                    supp_sel;
   logic [6:0]              dec_seg;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;
   logic [NUM_DIGITS-1:0]   an_nxt;

   assign slot_end = (presc == PRESC_LAST);
   assign wrap     = slot_end && (idx == IDX_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc      <= '0;
         idx        <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= wrap;
         if (slot_end) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

   // Display buffer only changes on the frame wrap, so a frame is never torn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_val <= '0;
         pend_dp  <= '0;
         disp_val <= '0;
         disp_dp  <= '0;
      end else begin
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
         end
         if (wrap) begin
            disp_val <= load ? value : pend_val;
            disp_dp  <= load ? dp_in : pend_dp;
         end
      end
   end

   // Digit i is dark when it and every more significant nibble are zero.
   always_comb begin
      supp = '0;
      for (int i = 1; i < NUM_DIGITS; i++)
         supp[i] = lz_en && ((disp_val >> (4 * i)) == '0);
   end

   always_comb begin
      nibble   = 4'h0;
      dp_sel   = 1'b0;
      supp_sel = 1'b0;
      an_sel   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            nibble    = disp_val[4*i +: 4];
            dp_sel    = disp_dp[i];
            supp_sel  = supp[i];
            an_sel[i] = 1'b1;
         end
      end
   end

   seven_seg_decoder u_decoder (
      .nibble (nibble),
      .seg    (dec_seg)
   );

   always_comb begin
      seg_nxt = (blank || supp_sel) ? SEG_OFF : dec_seg;
      dp_nxt  = !blank && dp_sel;
      an_nxt  = blank ? '0 : an_sel;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_POL;
         dp  <= DP_POL;
         an  <= AN_POL;
      end else begin
         seg <= seg_nxt ^ SEG_POL;
         dp  <= dp_nxt ^ DP_POL;
         an  <= an_nxt ^ AN_POL;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: a 4-digit instance and a 1-digit, inverted-polarity
// instance are compared each clock against an arithmetic reference model.
module tb_seven_seg_scan_driver;

   localparam int N     = 4;
   localparam int DIV   = 4;
   localparam int FRAME = N * DIV;
   localparam int DIV1  = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic        load = 1'b0;
   logic        blank = 1'b0;
   logic        lz_en = 1'b0;

   logic [6:0]  seg, seg1;
   logic        dp, dp1;
   logic [3:0]  an;
   logic [0:0]  an1;
   logic        frame_tick, frame_tick1;

   always #5 clk = ~clk;

   seven_seg_scan_driver #(
      .NUM_DIGITS(N), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
      .blank(blank), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
   );

   seven_seg_scan_driver #(
      .NUM_DIGITS(1), .REFRESH_DIV(DIV1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b0)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .value(value[3:0]), .dp_in(dp_in[0:0]), .load(load),
      .blank(blank), .lz_en(lz_en), .seg(seg1), .dp(dp1), .an(an1), .frame_tick(frame_tick1)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: clock edges since reset release plus what each display shows.
   int          edges;
   logic [15:0] shown, pend;
   logic [3:0]  shown_dp, pend_dp;
   logic [3:0]  shown1, pend1;
   logic        shown_dp1, pend_dp1;

   logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s at edge %0d: observed 0x%0h expected 0x%0h", tag, edges, obs, exp);
      end
   endtask

   task automatic model_reset();
      edges     = 0;
      shown     = '0;
      pend      = '0;
      shown_dp  = '0;
      pend_dp   = '0;
      shown1    = '0;
      pend1     = '0;
      shown_dp1 = 1'b0;
      pend_dp1  = 1'b0;
   endtask

   // One clock with the inputs currently applied; outputs checked #1 after the edge.
   task automatic step();
      int         slot;
      logic [3:0] e_an;
      logic [6:0] e_seg, e_seg1;
      logic       e_dp, e_dp1, e_an1;
      slot  = (edges / DIV) % N;
      e_an  = blank ? 4'hF : ~(4'b0001 << slot);
      if (blank || (lz_en && slot > 0 && (shown >> (4 * slot)) == 16'h0))
         e_seg = 7'h00;
      else
         e_seg = hex_tbl[shown[4*slot +: 4]];
      e_dp   = !blank && shown_dp[slot];
      e_an1  = !blank;
      e_seg1 = blank ? 7'h7F : ~hex_tbl[shown1];
      e_dp1  = !(!blank && shown_dp1);

      if ((edges + 1) % FRAME == 0) begin
         shown    = load ? value : pend;
         shown_dp = load ? dp_in : pend_dp;
      end
      if ((edges + 1) % DIV1 == 0) begin
         shown1    = load ? value[3:0] : pend1;
         shown_dp1 = load ? dp_in[0] : pend_dp1;
      end
      if (load) begin
         pend     = value;
         pend_dp  = dp_in;
         pend1    = value[3:0];
         pend_dp1 = dp_in[0];
      end

      @(posedge clk);
      #1;
      edges++;
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("frame_tick", 32'(frame_tick), 32'(edges % FRAME == 0));
      check("an1", 32'(an1), 32'(e_an1));
      check("seg1", 32'(seg1), 32'(e_seg1));
      check("dp1", 32'(dp1), 32'(e_dp1));
      check("frame_tick1", 32'(frame_tick1), 32'(edges % DIV1 == 0));
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic load_val(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dp_in = d;
      load  = 1'b1;
      step();
      load  = 1'b0;
   endtask

   task automatic check_reset_pins(input string tag);
      check({tag, "_an"}, 32'(an), 32'hF);
      check({tag, "_seg"}, 32'(seg), 32'h00);
      check({tag, "_dp"}, 32'(dp), 32'h0);
      check({tag, "_ft"}, 32'(frame_tick), 32'h0);
      check({tag, "_an1"}, 32'(an1), 32'h0);
      check({tag, "_seg1"}, 32'(seg1), 32'h7F);
      check({tag, "_dp1"}, 32'(dp1), 32'h1);
   endtask

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      #2 check_reset_pins("reset");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Scan pattern; the first frame still shows the reset value of zero.
      load_val(16'h1234, 4'h0);
      run(2 * FRAME);

      // Tear-free update from the middle of a frame.
      while (edges % FRAME != 6) step();
      load_val(16'hABCD, 4'h5);
      run(2 * FRAME);

      // Load in the cycle after the wrap (frame_tick high) and in the wrap cycle.
      while (edges % FRAME != 0) step();
      load_val(16'h00F0, 4'h0);
      run(FRAME + 3);
      while (edges % FRAME != FRAME - 1) step();
      load_val(16'h9876, 4'hA);
      run(FRAME);

      // Several loads in one frame: the last one is shown.
      load_val(16'h1111, 4'h1);
      run(2);
      load_val(16'h2222, 4'h2);
      run(2 * FRAME);

      // Leading-zero suppression keeps the dp of a dark digit.
      lz_en = 1'b1;
      load_val(16'h0050, 4'b1000);
      run(2 * FRAME);
      load_val(16'h0000, 4'b0000);
      run(2 * FRAME);
      lz_en = 1'b0;
      run(FRAME);

      // Blanking for 10 clocks from mid-frame.
      while (edges % FRAME != 5) step();
      blank = 1'b1;
      run(10);
      blank = 1'b0;
      run(FRAME);

      // Random traffic with frequent leading zeros.
      for (int k = 0; k < 400; k++) begin
         value = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
         dp_in = 4'($urandom);
         load  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 15) == 0) blank = ~blank;
         if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
         step();
      end
      load  = 1'b0;
      blank = 1'b0;
      lz_en = 1'b0;
      run(FRAME);

      // Asynchronous reset between edges mid-scan, with a pending load lost.
      while (edges % FRAME != 7) step();
      load_val(16'h5A5A, 4'hF);
      run(3);
      #2 rst_n = 1'b0;
      #1 check_reset_pins("async_reset");
      @(posedge clk);
      #1 check_reset_pins("held_reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run(2 * FRAME);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
